// File: rtl/pwm_ctrl_pkg.sv
// Address map and write-handshake states shared by the PWM controller and its channels.
package pwm_ctrl_pkg;

    localparam logic [7:0] ADDR_DUTY_BASE = 8'h00;
    localparam logic [7:0] ADDR_TOP       = 8'h10;
    localparam logic [7:0] ADDR_PRESCALE  = 8'h11;
    localparam logic [7:0] ADDR_EN        = 8'h12;
    localparam logic [7:0] ADDR_POL       = 8'h13;

    typedef enum logic {
        IDLE = 1'b0,
        ADDR = 1'b1
    } wr_state_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty, active enable/polarity and the registered output.
module pwm_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             duty_we,
    input  logic [WIDTH-1:0] duty_wdata,
    input  logic             load,
    input  logic             en_shadow,
    input  logic             pol_shadow,
    input  logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] duty_shadow,
    output logic             pwm_out
);

    logic [WIDTH-1:0] duty_shadow_q, duty_shadow_d;
    logic [WIDTH-1:0] duty_act_q, duty_act_d;
    logic             en_act_q, en_act_d;
    logic             pol_act_q, pol_act_d;
    logic             pwm_q, pwm_d;
    logic             raw;

    // The wrap load reads the pre-write shadow, so a same-cycle write waits one more period.
    always_comb begin
        duty_shadow_d = duty_we ? duty_wdata : duty_shadow_q;
        duty_act_d    = load ? duty_shadow_q : duty_act_q;
        en_act_d      = load ? en_shadow : en_act_q;
        pol_act_d     = load ? pol_shadow : pol_act_q;
        raw           = (cnt < duty_act_q);
        pwm_d         = en_act_q ? (raw ^ pol_act_q) : pol_act_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow_q <= '0;
            duty_act_q    <= '0;
            en_act_q      <= 1'b0;
            pol_act_q     <= 1'b0;
            pwm_q         <= 1'b0;
        end else begin
            duty_shadow_q <= duty_shadow_d;
            duty_act_q    <= duty_act_d;
            en_act_q      <= en_act_d;
            pol_act_q     <= pol_act_d;
            pwm_q         <= pwm_d;
        end
    end

    assign duty_shadow = duty_shadow_q;
    assign pwm_out     = pwm_q;

endmodule

// File: rtl/pwm_multi_channel_ctrl.sv
// Byte-programmed multi-channel PWM: address/data write FSM, shared prescaler and period counter.
module pwm_multi_channel_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int WIDTH = 8,
    parameter int PRE_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           wr_en,
    input  logic [7:0]     wr_data,
    output logic [7:0]     rd_data,
    output logic [NCH-1:0] pwm_out,
    output logic           period_done,
    output logic           wr_ack
);

    wr_state_e             state_q, state_d;
    logic [7:0]            addr_q, addr_d;
    logic                  wr_ack_q, wr_ack_d;
    logic [7:0]            rd_data_q, rd_data_d;
    logic [WIDTH-1:0]      top_q, top_d;
    logic [PRE_W-1:0]      prescale_q, prescale_d;
    logic [NCH-1:0]        en_q, en_d;
    logic [NCH-1:0]        pol_q, pol_d;
    logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0]      cnt_q, cnt_d;
    logic                  period_done_q, period_done_d;
    logic                  commit, tick, wrap;
    logic [NCH-1:0]        duty_we;
    logic [NCH-1:0][WIDTH-1:0] duty_shadow;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        commit  = 1'b0;
        if (!ena) begin
            state_d = IDLE;
        end else if (wr_en) begin
            case (state_q)
                IDLE: begin
                    addr_d  = wr_data;
                    state_d = ADDR;
                end
                ADDR: begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        wr_ack_d = commit;
    end

    always_comb begin
        top_d      = top_q;
        prescale_d = prescale_q;
        en_d       = en_q;
        pol_d      = pol_q;
        duty_we    = '0;
        if (commit) begin
            case (addr_q)
                ADDR_TOP:      top_d      = wr_data[WIDTH-1:0];
                ADDR_PRESCALE: prescale_d = PRE_W'(wr_data);
                ADDR_EN:       en_d       = NCH'(wr_data);
                ADDR_POL:      pol_d      = NCH'(wr_data);
                default: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (addr_q == ADDR_DUTY_BASE + 8'(i)) duty_we[i] = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        rd_data_d = '0;
        case (addr_q)
            ADDR_TOP:      rd_data_d = 8'(top_q);
            ADDR_PRESCALE: rd_data_d = 8'(prescale_q);
            ADDR_EN:       rd_data_d = 8'(en_q);
            ADDR_POL:      rd_data_d = 8'(pol_q);
            default: begin
                for (int i = 0; i < NCH; i++) begin
                    if (addr_q == ADDR_DUTY_BASE + 8'(i)) rd_data_d = 8'(duty_shadow[i]);
                end
            end
        endcase
    end

    // Compare with >= so a TOP or PRESCALE written below the running count wraps on the next tick.
    always_comb begin
        tick          = (pre_cnt_q >= prescale_q);
        pre_cnt_d     = tick ? '0 : pre_cnt_q + PRE_W'(1);
        wrap          = tick && (cnt_q >= top_q);
        cnt_d         = cnt_q;
        if (wrap) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
        period_done_d = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wr_ack_q      <= 1'b0;
            rd_data_q     <= '0;
            top_q         <= '1;
            prescale_q    <= '0;
            en_q          <= '0;
            pol_q         <= '0;
            pre_cnt_q     <= '0;
            cnt_q         <= '0;
            period_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wr_ack_q      <= wr_ack_d;
            rd_data_q     <= rd_data_d;
            top_q         <= top_d;
            prescale_q    <= prescale_d;
            en_q          <= en_d;
            pol_q         <= pol_d;
            pre_cnt_q     <= pre_cnt_d;
            cnt_q         <= cnt_d;
            period_done_q <= period_done_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .duty_we    (duty_we[g]),
            .duty_wdata (wr_data[WIDTH-1:0]),
            .load       (wrap),
            .en_shadow  (en_q[g]),
            .pol_shadow (pol_q[g]),
            .cnt        (cnt_q),
            .duty_shadow(duty_shadow[g]),
            .pwm_out    (pwm_out[g])
        );
    end

    assign rd_data     = rd_data_q;
    assign period_done = period_done_q;
    assign wr_ack      = wr_ack_q;

endmodule
